// File: rtl/strait_pkg.sv
// strait_pkg: shared state encoding and default depths for the STRAIT
// PE-array test controller.
// Config macro: STRAIT_TD_TEST_EN adds the transition-delay (TDL/TDC)
// states to the state enum; without it only the stuck-at flow exists.
package strait_pkg;

    localparam int STRAIT_N_DEF        = 8;
    localparam int STRAIT_SA_DEPTH_DEF = 12;
    localparam int STRAIT_TD_DEPTH_DEF = 18;

    typedef enum logic [3:0] {
        IDLE,
        SA_REQ,
        SA_WAIT,
`ifdef STRAIT_TD_TEST_EN
        TDL_REQ,
        TDL_WAIT,
        TDC_REQ,
        TDC_WAIT,
`endif
        WB,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/strait_fault_classify.sv
// strait_fault_classify: combinational row/column fault classifier.
// Ports: i_acc (N*N accumulated PE fail bits, bit r*N+c = PE(r,c)),
// o_row_fault[r] / o_col_fault[c] = 1 when that row/column has >= 2 fails.
module strait_fault_classify #(
    parameter int N = 8
) (
    input  logic [N*N-1:0] i_acc,
    output logic [N-1:0]   o_row_fault,
    output logic [N-1:0]   o_col_fault
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] w_row [N];
    logic [N-1:0] w_col [N];

    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            assign w_row[r][c] = i_acc[r*N+c];
            assign w_col[r][c] = i_acc[c*N+r];
        end
        // v & (v-1) drops the lowest set bit: nonzero only for >= 2 bits
        assign o_row_fault[r] = |(w_row[r] & (w_row[r] - ONE));
        assign o_col_fault[r] = |(w_col[r] & (w_col[r] - ONE));
    end

endmodule

// File: rtl/strait_test_ctrl.sv
// strait_test_ctrl: sequences stuck-at (and optionally transition-delay)
// pattern application over an NxN PE array, accumulates per-PE fails and
// writes the per-row result plus row/column fault vectors back to eNVM.
// Ports: clk/rst_n (async active-low); start, abort (control);
// apply_req/apply_done/pe_fail_flat (datapath handshake);
// test_type, TD_answer_choose, pattern_counter (pattern read);
// detection_en/addr, single_pe/row_fault/column_fault_detection (write);
// busy, done, any_fault (status).
// Config macro: STRAIT_TD_TEST_EN enables the TD phase (TDL then TDC per
// pattern); otherwise SA goes straight to write-back and test_type and
// TD_answer_choose are tied to 0.
module strait_test_ctrl
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE          = STRAIT_N_DEF,
    parameter int SA_TEST_PATTERN_DEPTH  = STRAIT_SA_DEPTH_DEF,
    parameter int TD_TEST_PATTERN_DEPTH  = STRAIT_TD_DEPTH_DEF,
    parameter int ADDR_WIDTH             = $clog2(SYSTOLIC_SIZE),
    parameter int MAX_PATTERN_ADDR_WIDTH =
        $clog2(max_int(SA_TEST_PATTERN_DEPTH, TD_TEST_PATTERN_DEPTH))
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              apply_req,
    input  logic                              apply_done,
    input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] pe_fail_flat,
    output logic                              test_type,
    output logic                              TD_answer_choose,
    output logic [MAX_PATTERN_ADDR_WIDTH-1:0] pattern_counter,
    output logic                              detection_en,
    output logic [ADDR_WIDTH-1:0]             detection_addr,
    output logic [SYSTOLIC_SIZE-1:0]          single_pe_detection,
    output logic [SYSTOLIC_SIZE-1:0]          row_fault_detection,
    output logic [SYSTOLIC_SIZE-1:0]          column_fault_detection,
    output logic                              busy,
    output logic                              done,
    output logic                              any_fault
);

    localparam int N  = SYSTOLIC_SIZE;
    localparam int PW = MAX_PATTERN_ADDR_WIDTH;

    localparam logic [PW-1:0] PC_ONE     = PW'(1);
    localparam logic [PW-1:0] PC_SA_LAST = PW'(SA_TEST_PATTERN_DEPTH - 1);
`ifdef STRAIT_TD_TEST_EN
    localparam logic [PW-1:0] PC_TD_LAST = PW'(TD_TEST_PATTERN_DEPTH - 1);
`endif
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(N - 1);

    state_t                  r_state;
    logic [N*N-1:0]          r_acc;
    logic                    r_apply_req;
    logic [PW-1:0]           r_pc;
    logic                    r_det_en;
    logic [ADDR_WIDTH-1:0]   r_det_addr;
    logic [N-1:0]            r_single;
    logic [N-1:0]            r_row;
    logic [N-1:0]            r_col;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_any_fault;
`ifdef STRAIT_TD_TEST_EN
    logic                    r_test_type;
    logic                    r_td_choose;
`endif

    logic [N*N-1:0]          w_acc_upd;
    logic [N-1:0]            w_row_fault;
    logic [N-1:0]            w_col_fault;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic [N-1:0]            w_next_row;

    // Classified from the updated accumulator so the final pattern's
    // fails are already included when write-back is entered.
    assign w_acc_upd   = r_acc | pe_fail_flat;
    assign w_next_addr = r_det_addr + ADDR_ONE;
    assign w_next_row  = r_acc[int'(w_next_addr)*N +: N];

    strait_fault_classify #(
        .N (N)
    ) u_classify (
        .i_acc       (w_acc_upd),
        .o_row_fault (w_row_fault),
        .o_col_fault (w_col_fault)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_apply_req <= 1'b0;
            r_pc        <= '0;
            r_det_en    <= 1'b0;
            r_det_addr  <= '0;
            r_single    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_any_fault <= 1'b0;
`ifdef STRAIT_TD_TEST_EN
            r_test_type <= 1'b0;
            r_td_choose <= 1'b0;
`endif
        end else if (abort && (r_state != IDLE)) begin
            r_state     <= IDLE;
            r_apply_req <= 1'b0;
            r_pc        <= '0;
            r_det_en    <= 1'b0;
            r_det_addr  <= '0;
            r_single    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef STRAIT_TD_TEST_EN
            r_test_type <= 1'b0;
            r_td_choose <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc       <= '0;
                        r_pc        <= '0;
                        r_any_fault <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= SA_REQ;
                    end
                end
                SA_REQ: begin
                    r_apply_req <= 1'b1;
                    r_state     <= SA_WAIT;
                end
                SA_WAIT: begin
                    if (apply_done) begin
                        r_acc       <= w_acc_upd;
                        r_apply_req <= 1'b0;
                        if (r_pc == PC_SA_LAST) begin
                            r_pc <= '0;
`ifdef STRAIT_TD_TEST_EN
                            r_test_type <= 1'b1;
                            r_td_choose <= 1'b0;
                            r_state     <= TDL_REQ;
`else
                            r_det_en   <= 1'b1;
                            r_det_addr <= '0;
                            r_single   <= w_acc_upd[N-1:0];
                            r_row      <= w_row_fault;
                            r_col      <= w_col_fault;
                            r_state    <= WB;
`endif
                        end else begin
                            r_pc    <= r_pc + PC_ONE;
                            r_state <= SA_REQ;
                        end
                    end
                end
`ifdef STRAIT_TD_TEST_EN
                TDL_REQ: begin
                    r_apply_req <= 1'b1;
                    r_state     <= TDL_WAIT;
                end
                TDL_WAIT: begin
                    if (apply_done) begin
                        r_acc       <= w_acc_upd;
                        r_apply_req <= 1'b0;
                        r_td_choose <= 1'b1;
                        r_state     <= TDC_REQ;
                    end
                end
                TDC_REQ: begin
                    r_apply_req <= 1'b1;
                    r_state     <= TDC_WAIT;
                end
                TDC_WAIT: begin
                    if (apply_done) begin
                        r_acc       <= w_acc_upd;
                        r_apply_req <= 1'b0;
                        r_td_choose <= 1'b0;
                        if (r_pc == PC_TD_LAST) begin
                            r_pc        <= '0;
                            r_test_type <= 1'b0;
                            r_det_en    <= 1'b1;
                            r_det_addr  <= '0;
                            r_single    <= w_acc_upd[N-1:0];
                            r_row       <= w_row_fault;
                            r_col       <= w_col_fault;
                            r_state     <= WB;
                        end else begin
                            r_pc    <= r_pc + PC_ONE;
                            r_state <= TDL_REQ;
                        end
                    end
                end
`endif
                WB: begin
                    if (r_det_addr == ADDR_LAST) begin
                        r_det_en    <= 1'b0;
                        r_det_addr  <= '0;
                        r_single    <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_done      <= 1'b1;
                        r_any_fault <= |r_acc;
                        r_state     <= DONE;
                    end else begin
                        r_det_addr <= w_next_addr;
                        r_single   <= w_next_row;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign apply_req              = r_apply_req;
    assign pattern_counter        = r_pc;
    assign detection_en           = r_det_en;
    assign detection_addr         = r_det_addr;
    assign single_pe_detection    = r_single;
    assign row_fault_detection    = r_row;
    assign column_fault_detection = r_col;
    assign busy                   = r_busy;
    assign done                   = r_done;
    assign any_fault              = r_any_fault;
`ifdef STRAIT_TD_TEST_EN
    assign test_type        = r_test_type;
    assign TD_answer_choose = r_td_choose;
`else
    assign test_type        = 1'b0;
    assign TD_answer_choose = 1'b0;
`endif

endmodule

// File: tb/tb_strait_test_ctrl.sv
// tb_strait_test_ctrl: directed scoreboard bench for strait_test_ctrl.
// Datapath responder answers every apply_req two cycles later.
module tb_strait_test_ctrl;

    localparam int N = 8;
`ifdef STRAIT_TD_TEST_EN
    localparam int TOTAL     = 12 + 2*18;
    localparam int ABORT_IDX = 12 + 2*7 + 1;
`else
    localparam int TOTAL     = 12;
    localparam int ABORT_IDX = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        apply_req;
    logic        apply_done;
    logic [63:0] pe_fail_flat;
    logic        test_type;
    logic        td_choose;
    logic [4:0]  pc;
    logic        det_en;
    logic [2:0]  det_addr;
    logic [7:0]  single;
    logic [7:0]  row_f;
    logic [7:0]  col_f;
    logic        busy;
    logic        done;
    logic        any_fault;

    always #5 clk = ~clk;

    strait_test_ctrl dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .abort                  (abort),
        .apply_req              (apply_req),
        .apply_done             (apply_done),
        .pe_fail_flat           (pe_fail_flat),
        .test_type              (test_type),
        .TD_answer_choose       (td_choose),
        .pattern_counter        (pc),
        .detection_en           (det_en),
        .detection_addr         (det_addr),
        .single_pe_detection    (single),
        .row_fault_detection    (row_f),
        .column_fault_detection (col_f),
        .busy                   (busy),
        .done                   (done),
        .any_fault              (any_fault)
    );

    typedef struct packed {
        logic       tt;
        logic       td;
        logic [4:0] pc;
    } app_t;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] single;
        logic [7:0] row;
        logic [7:0] col;
    } wb_t;

    app_t q_app[$];
    wb_t  q_wb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] row_model(input logic [63:0] a);
        logic [7:0] f;
        f = '0;
        for (int r = 0; r < N; r++) begin
            int cnt;
            cnt = 0;
            for (int c = 0; c < N; c++) cnt += int'(a[r*N+c]);
            f[r] = (cnt >= 2);
        end
        return f;
    endfunction

    function automatic logic [7:0] col_model(input logic [63:0] a);
        logic [7:0] f;
        f = '0;
        for (int c = 0; c < N; c++) begin
            int cnt;
            cnt = 0;
            for (int r = 0; r < N; r++) cnt += int'(a[r*N+c]);
            f[c] = (cnt >= 2);
        end
        return f;
    endfunction

    task automatic push_wb(input logic [63:0] acc);
        wb_t e;
        for (int a = 0; a < N; a++) begin
            e.addr   = 3'(a);
            e.single = acc[a*N +: N];
            e.row    = row_model(acc);
            e.col    = col_model(acc);
            q_wb.push_back(e);
        end
    endtask

    task automatic check_zero(input string p);
        chk({p, "_apply_req"}, 64'(apply_req), 64'(0));
        chk({p, "_test_type"}, 64'(test_type), 64'(0));
        chk({p, "_td_choose"}, 64'(td_choose), 64'(0));
        chk({p, "_pc"}, 64'(pc), 64'(0));
        chk({p, "_det_en"}, 64'(det_en), 64'(0));
        chk({p, "_det_addr"}, 64'(det_addr), 64'(0));
        chk({p, "_single"}, 64'(single), 64'(0));
        chk({p, "_row"}, 64'(row_f), 64'(0));
        chk({p, "_col"}, 64'(col_f), 64'(0));
        chk({p, "_busy"}, 64'(busy), 64'(0));
        chk({p, "_done"}, 64'(done), 64'(0));
        chk({p, "_any_fault"}, 64'(any_fault), 64'(0));
    endtask

    task automatic run_test(
        input int ia0, input logic [63:0] va0,
        input int ia1, input logic [63:0] va1,
        input int ia2, input logic [63:0] va2,
        input int abort_idx, input int rst_addr
    );
        int          n_app;
        int          rise_cyc;
        int          wb_cnt;
        bit          pending;
        bit          dropchk;
        bit          prev_req;
        bit          aborted;
        bit          finished;
        bit          seen_en;
        bit          seen_done;
        app_t        ea;
        wb_t         ew;
        logic [63:0] v;
        logic [63:0] m_acc;
        q_app.delete();
        q_wb.delete();
        for (int p = 0; p < 12; p++)
            q_app.push_back('{tt: 1'b0, td: 1'b0, pc: 5'(p)});
`ifdef STRAIT_TD_TEST_EN
        for (int p = 0; p < 18; p++) begin
            q_app.push_back('{tt: 1'b1, td: 1'b0, pc: 5'(p)});
            q_app.push_back('{tt: 1'b1, td: 1'b1, pc: 5'(p)});
        end
`endif
        m_acc = '0;
        n_app = 0;
        rise_cyc = 0;
        wb_cnt = 0;
        pending = 0;
        dropchk = 0;
        prev_req = 0;
        aborted = 0;
        finished = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start", 64'(busy), 64'(1));
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            apply_done = 1'b0;
            pe_fail_flat = {$urandom, $urandom};
            if (aborted) begin
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_req", 64'(apply_req), 64'(0));
                seen_en = 0;
                seen_done = 0;
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    seen_en |= det_en;
                    seen_done |= done;
                end
                chk("abort_no_wb", 64'(seen_en), 64'(0));
                chk("abort_no_done", 64'(seen_done), 64'(0));
                finished = 1;
            end else begin
                if (dropchk) begin
                    chk("req_drop", 64'(apply_req), 64'(0));
                    dropchk = 0;
                end
                if (pending) begin
                    if (cyc == rise_cyc + 2) begin
                        v = '0;
                        if (n_app == ia0) v |= va0;
                        if (n_app == ia1) v |= va1;
                        if (n_app == ia2) v |= va2;
                        apply_done = 1'b1;
                        pe_fail_flat = v;
                        pending = 0;
                        if (n_app == abort_idx) begin
                            abort = 1'b1;
                            aborted = 1;
                        end else begin
                            dropchk = 1;
                            m_acc |= v;
                        end
                        n_app++;
                        if (n_app == TOTAL && !aborted) push_wb(m_acc);
                    end else begin
                        chk("req_hold", 64'(apply_req), 64'(1));
                    end
                end else if (apply_req && !prev_req) begin
                    if (q_app.size() == 0) begin
                        chk("apply_count", 64'(n_app + 1), 64'(TOTAL));
                    end else begin
                        ea = q_app.pop_front();
                        chk("test_type", 64'(test_type), 64'(ea.tt));
                        chk("td_choose", 64'(td_choose), 64'(ea.td));
                        chk("pattern_counter", 64'(pc), 64'(ea.pc));
                    end
                    pending = 1;
                    rise_cyc = cyc;
                    if (n_app == 3) start = 1'b1;
                end
                prev_req = apply_req;
                if (det_en) begin
                    if (q_wb.size() == 0) begin
                        chk("wb_count", 64'(wb_cnt), 64'(N));
                    end else begin
                        ew = q_wb.pop_front();
                        chk("wb_addr", 64'(det_addr), 64'(ew.addr));
                        chk("wb_single", 64'(single), 64'(ew.single));
                        chk("wb_row", 64'(row_f), 64'(ew.row));
                        chk("wb_col", 64'(col_f), 64'(ew.col));
                    end
                    wb_cnt++;
                    apply_done = 1'b1;
                    pe_fail_flat = '1;
                    if (rst_addr >= 0 && int'(det_addr) == rst_addr) begin
                        rst_n = 1'b0;
                        #1;
                        check_zero("rst_wb");
                        apply_done = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        finished = 1;
                    end
                end
                if (done) begin
                    chk("apply_count", 64'(n_app), 64'(TOTAL));
                    chk("wb_count", 64'(wb_cnt), 64'(N));
                    chk("any_fault", 64'(any_fault), 64'(m_acc != '0));
                    chk("busy_in_done", 64'(busy), 64'(1));
                    @(negedge clk);
                    chk("done_pulse", 64'(done), 64'(0));
                    chk("busy_idle", 64'(busy), 64'(0));
                    chk("any_fault_hold", 64'(any_fault),
                        64'(m_acc != '0));
                    finished = 1;
                end
            end
        end
        chk("timeout", 64'(finished), 64'(1));
        start = 1'b0;
        abort = 1'b0;
        apply_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        apply_done = 1'b0;
        pe_fail_flat = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        run_test(-1, '0, -1, '0, -1, '0, -1, -1);

        run_test(5, 64'h1 << 19, -1, '0, -1, '0, -1, -1);
        repeat (2) @(negedge clk);
        chk("any_fault_held", 64'(any_fault), 64'(1));

        run_test(1, 64'h1, 4, 64'h2, TOTAL - 1, 64'h100, -1, -1);

        run_test(-1, '0, -1, '0, -1, '0, ABORT_IDX, -1);

        run_test(1, 64'h1, 4, 64'h2, TOTAL - 1, 64'h100, -1, 3);
        @(negedge clk);
        check_zero("post_rst");

        run_test(-1, '0, -1, '0, -1, '0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
